input_debounce_sync: RTL and testbench
======================================

// Module: input_debounce_sync
//
// PURPOSE
// - Conditions raw board inputs (buttons top/bottom/left/right/center,
//   joystick up/down/left/right/pressed) before they reach the board top.
// - Per bit: 2-FF synchronizer, then a counter-based debouncer, then edge
//   detection.
// - Drives stable levels plus one-cycle rise/fall pulses; the top uses these
//   instead of raw pins.
//
// PARAMETERS
// - N_IN             10  number of conditioned inputs
//   - bit order: [4:0] buttons top,bottom,left,right,center;
//     [9:5] joystick up,down,left,right,pressed
// - DEBOUNCE_CYCLES  16  consecutive cycles a new synced value must persist
//   to be accepted; legal range >= 1
// - CNT_W            $clog2(DEBOUNCE_CYCLES+1)  counter width (derived; do not override)
//
// PORTS
// - clk         in   1      system clock
// - rst_n       in   1      async active-low reset
// - raw_in      in   N_IN   asynchronous raw pin levels
// - level_out   out  N_IN   debounced stable level
// - rise_pulse  out  N_IN   1-cycle pulse on accepted 0->1
// - fall_pulse  out  N_IN   1-cycle pulse on accepted 1->0
// - any_rise    out  1      registered OR of the per-bit rise conditions
//
// BEHAVIOUR
// - Reset:
//   - one clock; reset is asynchronous and active-low (clk, rst_n).
//   - While rst_n=0, all flops clear: sync stages, counters, level_out,
//     rise_pulse, fall_pulse and any_rise are all 0.
//   - On release, counting starts from the first clk edge.
// - Sync: sync1 <= raw_in; sync2 <= sync1. sync2 is the only value the
//   debouncer sees.
// - Debounce, per bit, evaluated each edge:
//   - sync2 == level_out: cnt <= 0.
//   - sync2 != level_out and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//   - sync2 != level_out and cnt == DEBOUNCE_CYCLES-1:
//     - level_out <= sync2; cnt <= 0.
//     - rise_pulse or fall_pulse <= 1 in the same edge, per the direction.
// - Pulses:
//   - All outputs are registered.
//   - Each pulse is high for exactly one cycle: the first cycle in which
//     level_out shows the new value.
//   - rise_pulse and fall_pulse are never both high on one bit.
// - Latency: a raw change held steady appears on level_out exactly
//   DEBOUNCE_CYCLES+2 clk edges after its first sampling edge.
// - Glitch: any return of sync2 to level_out before acceptance clears cnt.
//   level_out does not change and no pulse is produced.
// - Counter never wraps; its maximum value is DEBOUNCE_CYCLES-1.
// - DEBOUNCE_CYCLES=1: accept on the first differing sync2 cycle (latency 3).
// - Bits are fully independent. Simultaneous changes on several bits give
//   simultaneous pulses.
// - any_rise is high in exactly the cycles where any rise_pulse bit is high.
// - Reset mid-debounce: the pending change is discarded. After release the
//   input must again persist DEBOUNCE_CYCLES cycles.
//
// STRUCTURE
// - Shared package board_io_pkg:
//   - bit-index localparams (BTN_TOP..BTN_CENTER, JOY_UP..JOY_PRESSED)
//   - N_BOARD_IN = 10
//   - default DEBOUNCE_CYCLES for simulation (16) and for hardware (1_000_000)
// - One sub-module: debounce_cell.
//   - Handles one bit: sync, counter, level, rise, fall.
//   - Instantiated N_IN times in a generate loop.
//   - The top only ORs the rise pulses into any_rise.
//
// TESTING
// - Reset: hold rst_n=0 with raw_in=10'h3FF for 5 cycles.
//   -> all outputs 0, no pulses.
// - Clean press, DEBOUNCE_CYCLES=16: raise raw_in[0] and hold.
//   -> level_out[0]=1 at edge 18; rise_pulse[0] and any_rise high that cycle
//      only.
// - Glitch: raise raw_in[4] for 10 cycles, then drop.
//   -> level_out and all pulses remain 0 throughout.
// - Release: after the press, drop raw_in[0].
//   -> fall_pulse[0] high for 1 cycle 18 edges later; no rise_pulse.
// - Simultaneous: raise raw_in[9:5] together.
//   -> rise_pulse[9:5]=5'b11111 in the same cycle; other bits 0.
// - Reset mid-count: assert rst_n=0 at cnt=8, release, keep raw high.
//   -> accepted 18 edges after release, not earlier.

Source files
------------

// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared board input indices and debounce defaults
package board_io_pkg;

    localparam int N_BOARD_IN = 10;

    localparam int BTN_TOP     = 0;
    localparam int BTN_BOTTOM  = 1;
    localparam int BTN_LEFT    = 2;
    localparam int BTN_RIGHT   = 3;
    localparam int BTN_CENTER  = 4;
    localparam int JOY_UP      = 5;
    localparam int JOY_DOWN    = 6;
    localparam int JOY_LEFT    = 7;
    localparam int JOY_RIGHT   = 8;
    localparam int JOY_PRESSED = 9;

    // Short window keeps simulation fast; the hardware window is ~10 ms at 100 MHz.
    localparam int DEBOUNCE_CYCLES_SIM = 16;
    localparam int DEBOUNCE_CYCLES_HW  = 1_000_000;

    function automatic int debounce_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - one-bit synchronizer, counter debouncer and edge detector
module debounce_cell
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int CNT_W           = debounce_cnt_w(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_cond
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             differs;
    logic             accept;
    logic             fall_cond;

    assign differs   = (sync2 != level);
    assign accept    = differs && (cnt == CNT_MAX);
    assign rise_cond = accept && sync2;
    assign fall_cond = accept && !sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= rise_cond;
            fall  <= fall_cond;
            // Any cycle agreeing with the accepted level restarts the window.
            if (!differs) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_debounce_sync.sv
// rtl/input_debounce_sync.sv - conditions raw board buttons and joystick inputs
module input_debounce_sync
    import board_io_pkg::*;
#(
    parameter int N_IN            = N_BOARD_IN,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] raw_in,
    output logic [N_IN-1:0] level_out,
    output logic [N_IN-1:0] rise_pulse,
    output logic [N_IN-1:0] fall_pulse,
    output logic            any_rise
);

    localparam int CNT_W = debounce_cnt_w(DEBOUNCE_CYCLES);

    logic [N_IN-1:0] rise_cond;

    for (genvar i = 0; i < N_IN; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw      (raw_in[i]),
            .level    (level_out[i]),
            .rise     (rise_pulse[i]),
            .fall     (fall_pulse[i]),
            .rise_cond(rise_cond[i])
        );
    end

    // Registered from the same conditions as rise_pulse so both align exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_rise <= 1'b0;
        end else begin
            any_rise <= |rise_cond;
        end
    end

endmodule

// File: tb/tb_input_debounce_sync.sv
// tb/tb_input_debounce_sync.sv - directed bench for input_debounce_sync
module tb_input_debounce_sync;

    logic       clk;
    logic       rst_n;
    logic [9:0] raw_in;
    logic [9:0] level_out, rise_pulse, fall_pulse;
    logic       any_rise;
    logic [9:0] level1, rise1, fall1;
    logic       any1;

    int n_checks = 0;
    int n_fail   = 0;

    input_debounce_sync #(.N_IN(10), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
        .level_out(level_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .any_rise(any_rise)
    );

    input_debounce_sync #(.N_IN(10), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
        .level_out(level1), .rise_pulse(rise1),
        .fall_pulse(fall1), .any_rise(any1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n  = 1'b0;
        raw_in = 10'h3FF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({level_out, rise_pulse, fall_pulse, any_rise} !== 31'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got lvl=%h r=%h f=%h a=%b, want all 0",
                         c, level_out, rise_pulse, fall_pulse, any_rise);
            end
            n_checks++;
            if ({level1, rise1, fall1, any1} !== 31'd0) begin
                n_fail++;
                $display("FAIL reset_outputs_d1 cycle %0d: got lvl=%h r=%h f=%h a=%b, want all 0",
                         c, level1, rise1, fall1, any1);
            end
        end
        @(negedge clk);
        raw_in = 10'h000;
        rst_n  = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        n_checks++;
        if ({level_out, rise_pulse, fall_pulse, any_rise} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got lvl=%h r=%h f=%h a=%b, want all 0",
                     level_out, rise_pulse, fall_pulse, any_rise);
        end
    endtask

    task automatic test_press();
        @(negedge clk);
        raw_in[0] = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            @(posedge clk); #1;
            n_checks++;
            if (level_out !== ((e >= 18) ? 10'h001 : 10'h000)) begin
                n_fail++;
                $display("FAIL press_level edge %0d: got %h, want %h",
                         e, level_out, (e >= 18) ? 10'h001 : 10'h000);
            end
            n_checks++;
            if ({rise_pulse, fall_pulse, any_rise} !== ((e == 18) ? {10'h001, 10'h000, 1'b1} : 21'd0)) begin
                n_fail++;
                $display("FAIL press_pulse edge %0d: got r=%h f=%h a=%b, want r=%h f=000 a=%b",
                         e, rise_pulse, fall_pulse, any_rise,
                         (e == 18) ? 10'h001 : 10'h000, e == 18);
            end
            n_checks++;
            if ({level1, rise1, any1} !== {((e >= 3) ? 10'h001 : 10'h000),
                                           ((e == 3) ? 10'h001 : 10'h000), e == 3}) begin
                n_fail++;
                $display("FAIL press_min_window edge %0d: got lvl=%h r=%h a=%b, want lvl=%h r=%h a=%b",
                         e, level1, rise1, any1, (e >= 3) ? 10'h001 : 10'h000,
                         (e == 3) ? 10'h001 : 10'h000, e == 3);
            end
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        raw_in[4] = 1'b1;
        repeat (10) @(negedge clk);
        raw_in[4] = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({level_out, rise_pulse, fall_pulse, any_rise} !== {10'h001, 10'h000, 10'h000, 1'b0}) begin
                n_fail++;
                $display("FAIL glitch edge %0d: got lvl=%h r=%h f=%h a=%b, want lvl=001 no pulses",
                         e, level_out, rise_pulse, fall_pulse, any_rise);
            end
        end
    endtask

    task automatic test_release();
        @(negedge clk);
        raw_in[0] = 1'b0;
        for (int e = 1; e <= 22; e++) begin
            @(posedge clk); #1;
            n_checks++;
            if (level_out !== ((e >= 18) ? 10'h000 : 10'h001)) begin
                n_fail++;
                $display("FAIL release_level edge %0d: got %h, want %h",
                         e, level_out, (e >= 18) ? 10'h000 : 10'h001);
            end
            n_checks++;
            if ({rise_pulse, fall_pulse, any_rise} !== ((e == 18) ? {10'h000, 10'h001, 1'b0} : 21'd0)) begin
                n_fail++;
                $display("FAIL release_pulse edge %0d: got r=%h f=%h a=%b, want r=000 f=%h a=0",
                         e, rise_pulse, fall_pulse, any_rise, (e == 18) ? 10'h001 : 10'h000);
            end
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        raw_in[9:5] = 5'b11111;
        for (int e = 1; e <= 22; e++) begin
            @(posedge clk); #1;
            n_checks++;
            if (level_out !== ((e >= 18) ? 10'h3E0 : 10'h000)) begin
                n_fail++;
                $display("FAIL simul_level edge %0d: got %h, want %h",
                         e, level_out, (e >= 18) ? 10'h3E0 : 10'h000);
            end
            n_checks++;
            if ({rise_pulse, fall_pulse, any_rise} !== ((e == 18) ? {10'h3E0, 10'h000, 1'b1} : 21'd0)) begin
                n_fail++;
                $display("FAIL simul_pulse edge %0d: got r=%h f=%h a=%b, want r=%h f=000 a=%b",
                         e, rise_pulse, fall_pulse, any_rise,
                         (e == 18) ? 10'h3E0 : 10'h000, e == 18);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        @(negedge clk);
        raw_in[1] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({level_out, rise_pulse, fall_pulse, any_rise} !== 31'd0) begin
            n_fail++;
            $display("FAIL midreset_clear: got lvl=%h r=%h f=%h a=%b, want all 0",
                     level_out, rise_pulse, fall_pulse, any_rise);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            @(posedge clk); #1;
            n_checks++;
            if (level_out !== ((e >= 18) ? 10'h3E2 : 10'h000)) begin
                n_fail++;
                $display("FAIL midreset_level edge %0d: got %h, want %h",
                         e, level_out, (e >= 18) ? 10'h3E2 : 10'h000);
            end
            n_checks++;
            if ({rise_pulse, fall_pulse, any_rise} !== ((e == 18) ? {10'h3E2, 10'h000, 1'b1} : 21'd0)) begin
                n_fail++;
                $display("FAIL midreset_pulse edge %0d: got r=%h f=%h a=%b, want r=%h f=000 a=%b",
                         e, rise_pulse, fall_pulse, any_rise,
                         (e == 18) ? 10'h3E2 : 10'h000, e == 18);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        raw_in = 10'h000;
        test_reset();
        test_press();
        test_glitch();
        test_release();
        test_simultaneous();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
